// File: rtl/sram_req_arbiter.sv
// Two-requester arbiter for a single SRAM-like bridge port.
// Data has fixed priority; a starvation counter eventually forces an inst grant.
module sram_req_arbiter #(
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         inst_req,
  input  logic                         inst_wr,
  input  logic [1:0]                   inst_size,
  input  logic [31:0]                  inst_addr,
  input  logic [31:0]                  inst_wdata,
  input  logic [3:0]                   inst_wstrb,
  output logic                         inst_addr_ok,
  output logic                         inst_data_ok,
  output logic [31:0]                  inst_rdata,
  input  logic                         data_req,
  input  logic                         data_wr,
  input  logic [1:0]                   data_size,
  input  logic [31:0]                  data_addr,
  input  logic [31:0]                  data_wdata,
  input  logic [3:0]                   data_wstrb,
  output logic                         data_addr_ok,
  output logic                         data_data_ok,
  output logic [31:0]                  data_rdata,
  output logic                         m_req,
  output logic                         m_wr,
  output logic [1:0]                   m_size,
  output logic [31:0]                  m_addr,
  output logic [31:0]                  m_wdata,
  output logic [3:0]                   m_wstrb,
  input  logic                         m_addr_ok,
  input  logic                         m_data_ok,
  input  logic [31:0]                  m_rdata,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         err_orphan
);

  localparam int AW = $clog2(MAX_OUTST);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_e;

  state_e               state_q;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [MAX_OUTST-1:0] tag_q;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 orphan_q, orphan_d;

  logic req_s, sel_data_s, accept_s, push_s, pop_s;
  logic empty_s, full_s, starved_s, head_s, inst_acc_s;

  assign empty_s   = (cnt_q == {CW{1'b0}});
  assign full_s    = (cnt_q == CW'(MAX_OUTST));
  assign starved_s = (starve_q == SW'(STARVE_LIMIT));
  assign head_s    = tag_q[rptr_q];

  // Winner selection; in LOCK states the mux stays on the locked requester.
  always_comb begin
    req_s      = 1'b0;
    sel_data_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_s) begin
          req_s      = 1'b0;
          sel_data_s = 1'b0;
        end else if (starved_s && inst_req) begin
          req_s      = 1'b1;
          sel_data_s = 1'b0;
        end else if (data_req) begin
          req_s      = 1'b1;
          sel_data_s = 1'b1;
        end else if (inst_req) begin
          req_s      = 1'b1;
          sel_data_s = 1'b0;
        end else begin
          req_s      = 1'b0;
          sel_data_s = 1'b0;
        end
      end
      LOCK_I: begin
        req_s      = inst_req;
        sel_data_s = 1'b0;
      end
      LOCK_D: begin
        req_s      = data_req;
        sel_data_s = 1'b1;
      end
      default: begin
        req_s      = 1'b0;
        sel_data_s = 1'b0;
      end
    endcase
  end

  // Reset gating keeps every handshake low while areset is high, before any edge.
  assign m_req        = req_s & ~areset;
  assign accept_s     = m_req & m_addr_ok;
  assign inst_addr_ok = accept_s & ~sel_data_s;
  assign data_addr_ok = accept_s & sel_data_s;
  assign push_s       = accept_s;
  assign pop_s        = m_data_ok & ~empty_s & ~areset;
  assign inst_data_ok = pop_s & ~head_s;
  assign data_data_ok = pop_s & head_s;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign outst_cnt    = cnt_q;
  assign err_orphan   = orphan_q;
  assign inst_acc_s   = inst_addr_ok;

  // Request field mux toward the bridge.
  always_comb begin
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    m_wstrb = 4'd0;
    if (m_req && sel_data_s) begin
      m_wr    = data_wr;
      m_size  = data_size;
      m_addr  = data_addr;
      m_wdata = data_wdata;
      m_wstrb = data_wstrb;
    end else if (m_req) begin
      m_wr    = inst_wr;
      m_size  = inst_size;
      m_addr  = inst_addr;
      m_wdata = inst_wdata;
      m_wstrb = inst_wstrb;
    end else begin
      m_wr    = 1'b0;
      m_size  = 2'd0;
      m_addr  = 32'd0;
      m_wdata = 32'd0;
      m_wstrb = 4'd0;
    end
  end

  // Tag FIFO pointer/count, starvation and orphan next-state.
  always_comb begin
    wptr_d   = push_s ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d   = pop_s ? (rptr_q + AW'(1)) : rptr_q;
    cnt_d    = cnt_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (!inst_req || inst_acc_s) begin
      starve_d = {SW{1'b0}};
    end else if (!starved_s) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
    orphan_d = orphan_q | (m_data_ok & empty_s & ~areset);
  end

  // Arbitration FSM: lock onto the winner until the bridge takes the address.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s && !m_addr_ok) state_q <= sel_data_s ? LOCK_D : LOCK_I;
          else                     state_q <= IDLE;
        end
        LOCK_I: begin
          if (!inst_req || m_addr_ok) state_q <= IDLE;
          else                        state_q <= LOCK_I;
        end
        LOCK_D: begin
          if (!data_req || m_addr_ok) state_q <= IDLE;
          else                        state_q <= LOCK_D;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO storage, counters and sticky error.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wptr_q   <= {AW{1'b0}};
      rptr_q   <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      tag_q    <= {MAX_OUTST{1'b0}};
      starve_q <= {SW{1'b0}};
      orphan_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      orphan_q <= orphan_d;
      if (push_s) tag_q[wptr_q] <= sel_data_s;
      else        tag_q <= tag_q;
    end
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like master port, the request side of the AXI bridge, between the instruction-fetch requester and the data requester.
- Selects one request at a time and holds the selection stable until the bridge accepts the address.
- Records the owner of each accepted request in an in-order tag FIFO, so each data_ok and its rdata go back to the correct requester.
- A starvation counter keeps the fixed data-over-inst priority from blocking instruction fetch indefinitely.

Parameters:
- MAX_OUTST, 4: depth of the owner-tag FIFO, i.e. the maximum number of accepted requests not yet answered by data_ok (power of 2, ≥2).
- STARVE_LIMIT, 8: number of consecutive cycles inst may lose arbitration before it is given priority.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- inst_req, inst_wr  in  1 each  inst request / write flag
- inst_size  in  2  0:1B, 1:2B, 2:4B
- inst_addr, inst_wdata  in  32 each
- inst_wstrb  in  4
- inst_addr_ok, inst_data_ok  out  1 each
- inst_rdata  out  32
- data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb  in  same widths as inst_*
- data_addr_ok, data_data_ok  out  1 each
- data_rdata  out  32
- m_req, m_wr  out  1 each  to bridge
- m_size  out  2
- m_addr, m_wdata  out  32 each
- m_wstrb  out  4
- m_addr_ok, m_data_ok  in  1 each  from bridge
- m_rdata  in  32
- outst_cnt  out  $clog2(MAX_OUTST)+1  number of occupied FIFO entries
- err_orphan  out  1  sticky error flag

Behaviour:
- Downstream contract: the bridge returns m_data_ok in acceptance order, one pulse per accepted request. A request must hold all fields stable from m_req=1 until the cycle of m_addr_ok.
- State machine (registered): IDLE, LOCK_I, LOCK_D.
- IDLE, winner selection (combinational):
  - If FIFO full: no winner, m_req=0.
  - Else if inst is starved (starve_cnt==STARVE_LIMIT) and inst_req=1: winner is inst.
  - Else if data_req=1: winner is data.
  - Else if inst_req=1: winner is inst.
  - m_* fields are muxed from the winner and m_req=1.
  - If m_addr_ok=1 in the same cycle: stay in IDLE.
  - Else: go to LOCK_I or LOCK_D according to the winner.
- LOCK_x:
  - The mux is fixed to requester x and m_req=x_req.
  - Stay until m_addr_ok=1, then return to IDLE.
  - If x_req drops before acceptance (protocol violation): return to IDLE and push nothing.
- Handshake to requesters:
  - inst_addr_ok = m_addr_ok & selected==inst; data_addr_ok likewise.
  - The non-selected requester sees addr_ok=0.
- Tag FIFO:
  - Push the 1-bit owner tag (0=inst, 1=data) on m_req & m_addr_ok.
  - Pop on m_data_ok when the FIFO is not empty.
  - Push and pop in the same cycle leave the count unchanged. This is legal when full (pop frees the slot), but m_req is already 0 when full, so no push occurs then.
  - Pointers wrap modulo MAX_OUTST; outst_cnt = number of occupied entries.
- Response routing (combinational, zero latency):
  - inst_data_ok = m_data_ok & ~empty & head==0; data_data_ok = m_data_ok & ~empty & head==1.
  - inst_rdata = data_rdata = m_rdata (qualified by data_ok).
- Orphan response: m_data_ok while the FIFO is empty drives no data_ok and sets err_orphan=1. It stays set until reset.
- Starvation counter (starve_cnt, 0..STARVE_LIMIT, saturating):
  - Increments each cycle inst_req=1 and inst is not accepted.
  - Cleared when inst is accepted or when inst_req=0.
- Reset values (asynchronous on areset=1):
  - State IDLE, FIFO empty, outst_cnt=0, starve_cnt=0, err_orphan=0.
  - All outputs 0: m_req and all *_ok low.
  - In-flight tags are discarded. The bridge must be reset together with this block.

Test Plan:
- Inst read only, addr 0x1C000000, bridge gives m_addr_ok after 2 cycles and m_data_ok 3 cycles later with rdata 0x12345678 -> fields stable during LOCK_I; inst_addr_ok one pulse; inst_data_ok one pulse with inst_rdata=0x12345678; outst_cnt 0→1→0.
- Both requesters request in the same cycle, m_addr_ok always 1 -> data granted first; inst granted the next cycle; data_ok returns are routed data then inst, matching tag order.
- data_req held high continuously with inst_req=1, STARVE_LIMIT=8 -> inst granted on the 9th cycle; starve_cnt returns to 0; data granted next.
- Issue 4 accepted requests with m_data_ok held low -> outst_cnt=4 and m_req=0 while full. Then one m_data_ok -> the head owner's data_ok pulses, m_req re-asserts, and after wrap the tags are still correct.
- m_data_ok pulse with the FIFO empty -> no data_ok on either requester; err_orphan=1 and it persists.
- areset asserted while in LOCK_D with 2 outstanding -> outputs clear immediately without waiting for a clock edge; outst_cnt=0; state IDLE after release.
